// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-memory arbiter: access size codes and FSM states.
package mips_dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic logic is_rsvd_size(input logic [1:0] size);
        return size == SZ_RSVD;
    endfunction

endpackage

// File: rtl/mips_dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields, accept pulse and response.
interface mips_dmem_arbiter_if;
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output valid, write, addr, wdata, size,
                    input  ready, rvalid, rdata, err);
    modport slave  (input  valid, write, addr, wdata, size,
                    output ready, rvalid, rdata, err);
endinterface

// File: rtl/mips_rr_arb2.sv
// Two-input round-robin grant; the pointer moves to the losing port after every grant.
module mips_rr_arb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (&req) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        // Port 0 winning favours port 1 next time, and vice versa.
        if (advance && |gnt) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= RR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port MIPS data memory.
// Define DMEM_ARB_RANGE_CHECK_EN to reject addresses >= DEPTH with err instead of a memory access.
module mips_dmem_arbiter
    import mips_dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mips_dmem_arbiter_if.slave        req0,
    mips_dmem_arbiter_if.slave        req1,
    output logic [31:0]               mem_address,
    output logic [31:0]               mem_write_data,
    output logic [1:0]                mem_byte_number,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [31:0]               mem_read_data
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("DEPTH must be at least 1");
    end

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  req_vec, gnt;
    logic        grant_any, sel, sel_write, sel_err, range_err;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;

    assign req_vec   = {req1.valid, req0.valid};
    assign grant_any = (state_q == ST_IDLE) && (|req_vec);

    mips_rr_arb2 #(.RR_INIT(RR_INIT)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vec),
        .advance (grant_any),
        .gnt     (gnt)
    );

    always_comb begin
        sel       = gnt[1];
        sel_write = sel ? req1.write : req0.write;
        sel_addr  = sel ? req1.addr  : req0.addr;
        sel_wdata = sel ? req1.wdata : req0.wdata;
        sel_size  = sel ? req1.size  : req0.size;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        range_err = sel_addr >= 32'(DEPTH);
`else
        range_err = 1'b0;
`endif
        sel_err   = is_rsvd_size(sel_size) || range_err;
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        mem_size_d    = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        rvalid_d      = 2'b00;
        rdata_d       = '0;
        err_d         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d = sel;
                    if (sel_err) begin
                        // Rejected requests skip the memory and answer one cycle early.
                        state_d  = ST_RESP;
                        rvalid_d = sel ? 2'b10 : 2'b01;
                        err_d    = 1'b1;
                    end else begin
                        state_d       = ST_ACCESS;
                        mem_address_d = sel_addr;
                        mem_wdata_d   = sel_wdata;
                        mem_size_d    = sel_size;
                        mem_read_d    = !sel_write;
                        mem_write_d   = sel_write;
                    end
                end
            end
            ST_ACCESS: begin
                state_d  = ST_RESP;
                rvalid_d = owner_q ? 2'b10 : 2'b01;
                rdata_d  = mem_read_q ? mem_read_data : 32'h0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_size_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            rvalid_q      <= 2'b00;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_size_q    <= mem_size_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign mem_address     = mem_address_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_byte_number = mem_size_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;

    // Accept pulses are masked while reset is held so no request is consumed then.
    assign req0.ready  = rst_n && grant_any && gnt[0];
    assign req1.ready  = rst_n && grant_any && gnt[1];
    assign req0.rvalid = rvalid_q[0];
    assign req1.rvalid = rvalid_q[1];
    assign req0.rdata  = rvalid_q[0] ? rdata_q : 32'h0;
    assign req1.rdata  = rvalid_q[1] ? rdata_q : 32'h0;
    assign req0.err    = rvalid_q[0] && err_q;
    assign req1.err    = rvalid_q[1] && err_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Self-checking bench for mips_dmem_arbiter with a behavioural data memory and response scoreboard.
module tb_mips_dmem_arbiter;
    import mips_dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_dmem_arbiter_if p0 ();
    mips_dmem_arbiter_if p1 ();

    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [1:0]  mem_byte_number;
    logic        mem_read, mem_write;

    mips_dmem_arbiter #(.DEPTH(256), .RR_INIT(1'b0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0            (p0),
        .req1            (p1),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_byte_number (mem_byte_number),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_read_data   (mem_read_data)
    );

    // Behavioural memory: sub-word stores update the low bits, loads zero-extend.
    logic [31:0] mem [0:511];
    logic [31:0] mem_word;
    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_byte_number)
                SZ_WORD: mem[mem_address[8:0]]       <= mem_write_data;
                SZ_HALF: mem[mem_address[8:0]][15:0] <= mem_write_data[15:0];
                SZ_BYTE: mem[mem_address[8:0]][7:0]  <= mem_write_data[7:0];
                default: ;
            endcase
        end
    end
    always_comb begin
        mem_word = mem[mem_address[8:0]];
        case (mem_byte_number)
            SZ_HALF: mem_read_data = {16'h0, mem_word[15:0]};
            SZ_BYTE: mem_read_data = {24'h0, mem_word[7:0]};
            default: mem_read_data = mem_word;
        endcase
    end

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    exp_t        mon_e;
    logic        mon_port;
    logic [31:0] mon_rdata;
    logic        mon_err;

    always @(negedge clk) begin
        if (rst_n && (p0.rvalid || p1.rvalid)) begin
            mon_port  = p1.rvalid;
            mon_rdata = p1.rvalid ? p1.rdata : p0.rdata;
            mon_err   = p1.rvalid ? p1.err : p0.err;
            chk_cnt++;
            if (p0.rvalid && p1.rvalid) begin
                $display("FAIL rvalid_both: rvalid0=%b rvalid1=%b, required only one", p0.rvalid, p1.rvalid);
            end else if (sb.size() == 0) begin
                $display("FAIL rvalid_unexpected: port %0d rvalid with no outstanding request", mon_port);
            end else begin
                mon_e = sb.pop_front();
                if (mon_port !== mon_e.port || mon_rdata !== mon_e.rdata || mon_err !== mon_e.err)
                    $display("FAIL response: got port=%0d rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                             mon_port, mon_rdata, mon_err, mon_e.port, mon_e.rdata, mon_e.err);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic drive_port(input logic port, input logic vld, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
        if (port) begin
            p1.valid = vld; p1.write = wr; p1.addr = addr; p1.wdata = wdata; p1.size = size;
        end else begin
            p0.valid = vld; p0.write = wr; p0.addr = addr; p0.wdata = wdata; p0.size = size;
        end
    endtask

    // Issue one request, wait for its accept, push the expected response; returns just after the accept edge.
    task automatic do_req(input logic port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic [31:0] exp_rdata, input logic exp_err);
        bit acc = 0;
        @(negedge clk);
        drive_port(port, 1'b1, wr, addr, wdata, size);
        for (int i = 0; i < 30 && !acc; i++) begin
            #1;
            if (port ? p1.ready : p0.ready) acc = 1;
            else @(negedge clk);
        end
        if (!acc) begin
            chk_cnt++;
            $display("FAIL accept_timeout: port %0d ready=0, required 1 within 30 cycles", port);
            drive_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
            return;
        end
        sb.push_back('{port, exp_rdata, exp_err});
        grant_log.push_back(port);
        @(posedge clk);
        #1;
        drive_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_port(1'b0, 1'b1, 1'b1, 32'h5, 32'h1, SZ_WORD);
        drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({p0.ready, p0.rvalid, p1.ready, p1.rvalid, mem_read, mem_write} !== 6'b0 ||
            mem_address !== 32'h0 || mem_write_data !== 32'h0)
            $display("FAIL reset_outputs: ctrl=%b addr=%h wdata=%h, required all 0",
                     {p0.ready, p0.rvalid, p1.ready, p1.rvalid, mem_read, mem_write}, mem_address, mem_write_data);
        else pass_cnt++;
        drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, SZ_WORD, 32'h0, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'd5 ||
            mem_write_data !== 32'hDEADBEEF || mem_byte_number !== SZ_WORD)
            $display("FAIL store_strobe: wr=%b rd=%b addr=%h data=%h sz=%b, required 1 0 5 deadbeef 00",
                     mem_write, mem_read, mem_address, mem_write_data, mem_byte_number);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (p0.rvalid !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h0)
            $display("FAIL store_resp_timing: rvalid=%b mem_write=%b addr=%h, required 1 0 0",
                     p0.rvalid, mem_write, mem_address);
        else pass_cnt++;
        wait_drain();
        do_req(1'b0, 1'b0, 32'd5, 32'h0, SZ_WORD, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || p0.rvalid !== 1'b0)
            $display("FAIL load_strobe: rd=%b wr=%b rvalid=%b, required 1 0 0", mem_read, mem_write, p0.rvalid);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (p0.rvalid !== 1'b1 || p1.rvalid !== 1'b0)
            $display("FAIL load_resp_timing: rvalid0=%b rvalid1=%b, required 1 0", p0.rvalid, p1.rvalid);
        else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_port1_sizes();
        do_req(1'b1, 1'b1, 32'd7, 32'h123456AB, SZ_BYTE, 32'h0, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b1 || mem_byte_number !== SZ_BYTE)
            $display("FAIL byte_store_size: wr=%b sz=%b, required 1 10", mem_write, mem_byte_number);
        else pass_cnt++;
        wait_drain();
        do_req(1'b1, 1'b0, 32'd7, 32'h0, SZ_WORD, 32'h000000AB, 1'b0);
        wait_drain();
        do_req(1'b1, 1'b1, 32'd7, 32'hCAFE1234, SZ_HALF, 32'h0, 1'b0);
        wait_drain();
        do_req(1'b1, 1'b0, 32'd7, 32'h0, SZ_WORD, 32'h00001234, 1'b0);
        wait_drain();
        do_req(1'b1, 1'b0, 32'd7, 32'h0, SZ_BYTE, 32'h00000034, 1'b0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic exp_order [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) do_req(1'b0, 1'b0, 32'd5, 32'h0, SZ_WORD, 32'hDEADBEEF, 1'b0);
            for (int j = 0; j < 3; j++) do_req(1'b1, 1'b0, 32'd7, 32'h0, SZ_WORD, 32'h00001234, 1'b0);
        join
        wait_drain();
        chk_cnt++;
        if (grant_log.size() != 6)
            $display("FAIL rr_count: %0d grants, required 6", grant_log.size());
        else pass_cnt++;
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            chk_cnt++;
            if (grant_log[k] !== exp_order[k])
                $display("FAIL rr_order[%0d]: granted port %0d, required %0d", k, grant_log[k], exp_order[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rsvd_size();
        do_req(1'b0, 1'b1, 32'd3, 32'h33333333, SZ_WORD, 32'h0, 1'b0);
        wait_drain();
        do_req(1'b0, 1'b1, 32'd3, 32'hFFFFFFFF, SZ_RSVD, 32'h0, 1'b1);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || p0.rvalid !== 1'b1 || p0.err !== 1'b1)
            $display("FAIL rsvd_timing: wr=%b rd=%b rvalid=%b err=%b, required 0 0 1 1",
                     mem_write, mem_read, p0.rvalid, p0.err);
        else pass_cnt++;
        wait_drain();
        do_req(1'b0, 1'b0, 32'd3, 32'h0, SZ_WORD, 32'h33333333, 1'b0);
        wait_drain();
    endtask

    task automatic test_range();
`ifdef DMEM_ARB_RANGE_CHECK_EN
        do_req(1'b1, 1'b1, 32'd256, 32'h5A5A5A5A, SZ_WORD, 32'h0, 1'b1);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b0 || p1.rvalid !== 1'b1 || p1.err !== 1'b1)
            $display("FAIL range_reject: wr=%b rvalid=%b err=%b, required 0 1 1", mem_write, p1.rvalid, p1.err);
        else pass_cnt++;
`else
        do_req(1'b1, 1'b1, 32'd256, 32'h5A5A5A5A, SZ_WORD, 32'h0, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b1 || mem_address !== 32'd256 || p1.rvalid !== 1'b0)
            $display("FAIL range_pass: wr=%b addr=%h rvalid=%b, required 1 100 0", mem_write, mem_address, p1.rvalid);
        else pass_cnt++;
`endif
        wait_drain();
    endtask

    task automatic test_reset_mid_access();
        do_req(1'b0, 1'b1, 32'd9, 32'h99999999, SZ_WORD, 32'h0, 1'b0);
        @(negedge clk);
        chk_cnt++;
        if (mem_write !== 1'b1)
            $display("FAIL pre_reset_strobe: mem_write=%b, required 1", mem_write);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== 32'h0 || p0.rvalid !== 1'b0)
            $display("FAIL async_reset: wr=%b rd=%b addr=%h rvalid=%b, required 0 0 0 0",
                     mem_write, mem_read, mem_address, p0.rvalid);
        else pass_cnt++;
        sb.delete();
        grant_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        fork
            do_req(1'b0, 1'b0, 32'd9, 32'h0, SZ_WORD, 32'h0, 1'b0);
            do_req(1'b1, 1'b0, 32'd9, 32'h0, SZ_WORD, 32'h0, 1'b0);
        join
        wait_drain();
        chk_cnt++;
        if (grant_log.size() == 0 || grant_log[0] !== 1'b0)
            $display("FAIL rr_after_reset: first grant port %0d (log size %0d), required 0",
                     grant_log.size() ? grant_log[0] : 1'bx, grant_log.size());
        else pass_cnt++;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 32'h0;
        test_reset();
        test_store_load();
        test_port1_sizes();
        test_back_to_back();
        test_rsvd_size();
        test_range();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
